uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, the upstream stage of the UART receiver top level. Its tx output drives the receiver's s_data line, both on-chip for loopback and off-chip.
- Accepts parallel bytes over a valid/ready handshake and buffers one byte ahead of the shifter.
- Emits 8N1 frames, LSB first, at a parameterised bit period, so back-to-back frames run with no idle gap.

Parameters:
- CLKS_PER_BIT, 35, clk cycles per serial bit. 35 × 80 ns = 2800 ns at the 12.5 MHz board clock. Must be ≥ 2.
- DATA_BITS, 8, data bits per frame. Range 5..8.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low. Sampled on the rising edge of clk; 0 = reset.
- din  in  DATA_BITS  byte to send. Sampled when din_valid and din_ready are both 1.
- din_valid  in  1  producer has a byte on din.
- din_ready  out  1  holding register empty; a byte is accepted this cycle if din_valid = 1.
- tx  out  1  serial line, registered. Idle = 1.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Reset (reset = 0 at an edge):
  - tx = 1, busy = 0, done = 0, din_ready = 1, hold_full = 0, state = IDLE, counters = 0.
  - Overrides everything, including mid-frame: the frame is truncated, tx returns to 1 on that edge, and any held byte is discarded.
- Accept: at an edge with din_valid & din_ready, din is latched into hold_reg and hold_full is set.
  - din_ready = ~hold_full.
  - din is ignored while din_ready = 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If hold_full, load the shifter from hold_reg, clear hold_full, go to START, and clear baud_cnt and bit_idx.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shifter[0]. Each bit is held CLKS_PER_BIT cycles, then the shifter shifts right and bit_idx increments. After bit DATA_BITS-1, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. done = 1 in the final cycle.
    - If hold_full at that final edge, transfer hold_reg → shifter and go directly to START (zero idle gap).
    - Otherwise go to IDLE.
- Bit timing: baud_cnt counts 0..CLKS_PER_BIT-1 and wraps. Each bit lasts exactly CLKS_PER_BIT cycles. One frame = (DATA_BITS + 2) × CLKS_PER_BIT cycles.
- Latency:
  - Accept edge E0 → hold_full = 1. At E1 the FSM leaves IDLE and tx falls.
  - tx = 0 is therefore first visible after the edge following the accept edge.
- Buffering:
  - While a frame is shifting, one further byte may be accepted into hold_reg; din_ready then drops.
  - din_ready rises again the cycle after the hold→shifter transfer.
  - Accept and transfer can never occur on the same edge, because din_ready = 0 whenever hold_full = 1.
- busy = 1 from the first START cycle until the cycle after the final STOP cycle when returning to IDLE. busy stays 1 continuously across back-to-back frames.
- Widths:
  - baud_cnt: $clog2(CLKS_PER_BIT) bits.
  - bit_idx: $clog2(DATA_BITS) bits.
  - No arithmetic overflow beyond the counter wrap.

Decomposition:
- Shared header uart_defs.vh holds:
  - FSM state encodings (IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3).
  - Default CLKS_PER_BIT and DATA_BITS.
  - The receiver uses the same header so both ends agree on framing.
- One natural sub-module: uart_baud_gen.
  - Counter with a synchronous clear; emits bit_end when the count reaches CLKS_PER_BIT-1.
  - The receiver can reuse it.

Test Plan:
- Reset, then send din = 8'hA6 → tx = 1 while idle; start bit 0 for 35 cycles; data bits 0,1,1,0,0,1,0,1 for 35 cycles each; stop bit 1. done pulses once, 350 cycles after tx falls. The downstream receiver's d_out = 8'hA6.
- Two bytes, 8'h55 then 8'hFF, with din_valid held high → second byte accepted mid-frame; din_ready is low until the transfer; STOP of the first frame is followed immediately by START (700 cycles total, no idle gap); done pulses twice, 350 cycles apart.
- Third byte offered while hold_full = 1 → not accepted; din_ready = 0; the byte is sent only after the next transfer.
- Assert reset = 0 during DATA bit 3 of 8'h0F, with a held byte pending → tx = 1, busy = 0, din_ready = 1 on the next edge; no further transmission of either byte; no done pulse.
- din_valid = 1 while reset = 0 → nothing accepted; tx stays 1.
- CLKS_PER_BIT = 2, DATA_BITS = 5, din = 5'b10011 → bits 1,1,0,0,1 each held 2 cycles; frame = 14 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART framing definitions (states, defaults, width helper)
package uart_tx_pkg;

    // Frame FSM states; the receiver uses the same encoding so both ends agree on framing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 35;
    localparam int DEF_DATA_BITS    = 8;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and bit_end strobe
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    localparam int CW          = cnt_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    output logic [CW-1:0] cnt_o,
    output logic          bit_end_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_w;

    assign last_w    = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign cnt_o     = cnt_q;
    assign bit_end_o = last_w;

    // Next count: wrap at the end of each bit period, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || last_w) begin
            cnt_d = '0;
        end
    end

    // Count register, zeroed by the active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(DATA_BITS);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic [DATA_BITS-1:0] shifter_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [CW-1:0]        baud_cnt;
    logic                 bit_end;
    logic                 accept;
    logic                 stop_pre_last;

    // The bit timer sits at zero while idle so the start bit gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .cnt_o     (baud_cnt),
        .bit_end_o (bit_end)
    );

    assign din_ready = ~hold_full_q;
    assign accept    = din_valid & ~hold_full_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // One cycle before the last stop-bit cycle, so done can be registered onto that last cycle.
    assign stop_pre_last = (state_q == STOP) && (baud_cnt == CW'(CLKS_PER_BIT - 2));

    // Holding register, frame FSM and registered line outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shifter_q   <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= stop_pre_last;

            // A byte can only land while the holding register is empty, so it never
            // collides with the hold-to-shifter transfer below.
            if (accept) begin
                hold_q      <= din;
                hold_full_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (hold_full_q) begin
                        shifter_q   <= hold_q;
                        hold_full_q <= 1'b0;
                        bit_idx_q   <= '0;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shifter_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shifter_q <= shifter_q >> 1;
                            tx_q      <= shifter_q[1];
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (hold_full_q) begin
                            // Chain straight into the next frame with no idle gap.
                            shifter_q   <= hold_q;
                            hold_full_q <= 1'b0;
                            bit_idx_q   <= '0;
                            tx_q        <= 1'b0;
                            state_q     <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-position reference model
module tb_uart_tx;

    localparam int CPB  = 35;
    localparam int DB   = 8;
    localparam int F    = (DB + 2) * CPB;
    localparam int LOGN = 16384;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] din       = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, tx, busy, done;

    logic [4:0] s_din   = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, s_tx, s_busy, s_done;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .busy(busy), .done(done)
    );

    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut_s (
        .clk(clk), .reset(reset), .din(s_din), .din_valid(s_valid),
        .din_ready(s_ready), .tx(s_tx), .busy(s_busy), .done(s_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a position counter 0..F-1 over a byte; at most one byte waits.
    bit         m_active    = 1'b0;
    int         m_t         = 0;
    logic [7:0] m_byte      = '0;
    logic [7:0] m_hold      = '0;
    bit         m_hold_full = 1'b0;
    bit         m_acc;

    function automatic logic m_tx_exp();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= DB) return m_byte[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_active    = 1'b0;
            m_t         = 0;
            m_hold_full = 1'b0;
        end else begin
            m_acc = din_valid && !m_hold_full;
            if (m_active) begin
                if (m_t == F - 1) begin
                    if (m_hold_full) begin
                        m_byte      = m_hold;
                        m_hold_full = 1'b0;
                        m_t         = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_t++;
                end
            end else if (m_hold_full) begin
                m_active    = 1'b1;
                m_t         = 0;
                m_byte      = m_hold;
                m_hold_full = 1'b0;
            end
            if (m_acc) begin
                m_hold      = din;
                m_hold_full = 1'b1;
            end
        end
    end

    logic tx_log    [LOGN];
    logic done_log  [LOGN];
    logic busy_log  [LOGN];
    logic ready_log [LOGN];
    int   cyc = 0;

    always @(negedge clk) begin
        tx_log[cyc % LOGN]    = tx;
        done_log[cyc % LOGN]  = done;
        busy_log[cyc % LOGN]  = busy;
        ready_log[cyc % LOGN] = din_ready;
        cyc++;
        check("model_tx", tx, m_tx_exp());
        check("model_busy", busy, m_active);
        check("model_done", done, m_active && (m_t == F - 1));
        check("model_din_ready", din_ready, !m_hold_full);
    end

    function automatic int last();
        return cyc - 1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_until(input int idx);
        while (last() < idx) step();
    endtask

    function automatic logic [9:0] grab(input int s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = tx_log[(s + i * CPB + CPB / 2) % LOGN];
        return r;
    endfunction

    function automatic int count_done(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (done_log[i % LOGN]) n++;
        return n;
    endfunction

    // Offer one byte from idle; s is the log index of the first start-bit cycle.
    task automatic send_one(input logic [7:0] b, output int s);
        step();
        din = b;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        s = last();
    endtask

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s;
        int errs;
        logic [15:0] s_txv, s_donev, s_busyv;

        vecs[0] = '{8'hA6, 10'h34C};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h5A, 10'h2B4};

        // Reset state, with din_valid asserted to show nothing is accepted.
        reset = 1'b0;
        din = 8'hC3;
        din_valid = 1'b1;
        steps(4);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_din_ready", din_ready, 1'b1);
        din_valid = 1'b0;
        reset = 1'b1;
        steps(2);
        check("idle_tx", tx, 1'b1);

        // Narrow configuration: 2 clocks per bit, 5 data bits.
        step();
        s_din = 5'b10011;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check("small_hold_tx", s_tx, 1'b1);
        check("small_hold_ready", s_ready, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            s_txv[i]   = s_tx;
            s_donev[i] = s_done;
            s_busyv[i] = s_busy;
        end
        check("small_frame_tx", s_txv, 16'hFC3C);
        check("small_frame_done", s_donev, 16'h2000);
        check("small_frame_busy", s_busyv, 16'h3FFF);

        // Single frames from idle.
        for (int v = 0; v < 4; v++) begin
            send_one(vecs[v].din, s);
            wait_until(s + F + 2);
            check("vec_latency_pre", tx_log[(s - 1) % LOGN], 1'b1);
            check("vec_latency_start", tx_log[s % LOGN], 1'b0);
            check("vec_frame", grab(s), vecs[v].frame);
            check("vec_done_count", count_done(s, s + F + 1), 1);
            check("vec_done_pos", done_log[(s + F - 1) % LOGN], 1'b1);
            check("vec_busy_end", busy_log[(s + F) % LOGN], 1'b0);
        end

        // Back-to-back: second byte taken mid-frame, frames abut.
        step();
        din = 8'h55;
        din_valid = 1'b1;
        step();
        din = 8'hFF;
        step();
        s = last();
        step();
        din_valid = 1'b0;
        wait_until(s + 2 * F + 10);
        check("b2b_frame0", grab(s), 10'h2AA);
        check("b2b_frame1", grab(s + F), 10'h3FE);
        check("b2b_done_count", count_done(s, s + 2 * F + 5), 2);
        check("b2b_done0", done_log[(s + F - 1) % LOGN], 1'b1);
        check("b2b_done1", done_log[(s + 2 * F - 1) % LOGN], 1'b1);
        check("b2b_no_gap", tx_log[(s + F) % LOGN], 1'b0);
        check("b2b_ready_low", ready_log[(s + F - 1) % LOGN], 1'b0);
        check("b2b_ready_back", ready_log[(s + F) % LOGN], 1'b1);
        errs = 0;
        for (int i = s; i < s + 2 * F; i++) if (!busy_log[i % LOGN]) errs++;
        check("b2b_busy_gaps", errs, 0);

        // Third byte offered while the holding register is full waits for the transfer.
        step();
        din = 8'h81;
        din_valid = 1'b1;
        step();
        din = 8'h42;
        step();
        s = last();
        step();
        din = 8'h3C;
        steps(20);
        errs = 0;
        for (int i = s + 2; i <= last(); i++) if (ready_log[i % LOGN]) errs++;
        check("third_ready_low", errs, 0);
        wait_until(s + F + 1);
        din_valid = 1'b0;
        wait_until(s + 3 * F + 10);
        check("third_frame0", grab(s), {1'b1, 8'h81, 1'b0});
        check("third_frame1", grab(s + F), {1'b1, 8'h42, 1'b0});
        check("third_frame2", grab(s + 2 * F), {1'b1, 8'h3C, 1'b0});
        check("third_done_count", count_done(s, s + 3 * F + 5), 3);

        // Reset during data bit 3 with a byte pending.
        step();
        din = 8'h0F;
        din_valid = 1'b1;
        step();
        din = 8'hAA;
        step();
        s = last();
        step();
        din_valid = 1'b0;
        wait_until(s + 150);
        check("rst_mid_bit3", tx_log[(s + 150) % LOGN], 1'b1);
        check("rst_mid_busy_before", busy_log[(s + 150) % LOGN], 1'b1);
        reset = 1'b0;
        din = 8'h5A;
        din_valid = 1'b1;
        steps(3);
        reset = 1'b1;
        din_valid = 1'b0;
        check("rst_mid_tx", tx_log[(s + 151) % LOGN], 1'b1);
        check("rst_mid_busy", busy_log[(s + 151) % LOGN], 1'b0);
        check("rst_mid_ready", ready_log[(s + 151) % LOGN], 1'b1);
        steps(400);
        errs = 0;
        for (int i = s + 151; i <= last(); i++)
            if (!tx_log[i % LOGN] || done_log[i % LOGN] || busy_log[i % LOGN]) errs++;
        check("rst_mid_silent", errs, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 6000; i++) begin
            step();
            din = 8'($urandom);
            din_valid = ($urandom_range(0, 3) == 0);
        end
        step();
        din_valid = 1'b0;
        steps(2 * F + 20);
        check("drain_idle_busy", busy, 1'b0);
        check("drain_idle_tx", tx, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
